// File: rtl/regfile_pkg.sv
// Shared widths and FSM state type for the register-file dump reader.
package regfile_pkg;
  localparam int DATA_W   = 32;
  localparam int ADDR_W   = 5;
  localparam int NUM_REGS = 2 ** ADDR_W;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    SEND = 2'd2,
    DONE = 2'd3
  } dump_state_t;
endpackage

// File: rtl/regfile_dump_reader_if.sv
// Valid/ready beat channel carrying one register snapshot per transfer.
interface regfile_dump_reader_if;
  import regfile_pkg::*;

  logic              dump_valid;
  logic              dump_ready;
  logic [DATA_W-1:0] dump_data;
  logic [ADDR_W-1:0] dump_index;
  logic              dump_last;

  modport master (
    output dump_valid, dump_data, dump_index, dump_last,
    input  dump_ready
  );

  modport slave (
    input  dump_valid, dump_data, dump_index, dump_last,
    output dump_ready
  );
endinterface

// File: rtl/regfile_dump_reader.sv
// Walks an inclusive register range through a combinational read port and
// streams each captured word out as one valid/ready beat.
module regfile_dump_reader
  import regfile_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [ADDR_W-1:0]     first_reg,
  input  logic [ADDR_W-1:0]     last_reg,
  input  logic                  abort,
  output logic [ADDR_W-1:0]     rf_addr,
  input  logic [DATA_W-1:0]     rf_data,
  output logic                  busy,
  output logic                  done,
  regfile_dump_reader_if.master dump
);
  dump_state_t       state_q, state_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic [ADDR_W-1:0] last_q, last_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [ADDR_W-1:0] index_q, index_d;
  logic              last_flag_q, last_flag_d;
  logic              valid_q, valid_d;
  logic              done_q, done_d;
  logic              busy_q, busy_d;

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    last_d      = last_q;
    data_d      = data_q;
    index_d     = index_q;
    last_flag_d = last_flag_q;
    valid_d     = valid_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          if (first_reg <= last_reg) begin
            last_d  = last_reg;
            idx_d   = first_reg;
            state_d = READ;
          end else begin
            state_d = DONE;
          end
        end
      end
      READ: begin
        if (abort) begin
          state_d = DONE;
        end else begin
          data_d      = rf_data;
          index_d     = idx_q;
          last_flag_d = (idx_q == last_q);
          valid_d     = 1'b1;
          state_d     = SEND;
        end
      end
      SEND: begin
        // abort wins over a simultaneous handshake: that beat is not counted
        if (abort) begin
          valid_d = 1'b0;
          state_d = DONE;
        end else if (dump.dump_ready) begin
          valid_d = 1'b0;
          if (last_flag_q) begin
            state_d = DONE;
          end else begin
            idx_d   = idx_q + 1'b1;
            state_d = READ;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    done_d = (state_d == DONE);
    busy_d = (state_d == READ) || (state_d == SEND);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      last_q      <= '0;
      data_q      <= '0;
      index_q     <= '0;
      last_flag_q <= 1'b0;
      valid_q     <= 1'b0;
      done_q      <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      last_q      <= last_d;
      data_q      <= data_d;
      index_q     <= index_d;
      last_flag_q <= last_flag_d;
      valid_q     <= valid_d;
      done_q      <= done_d;
      busy_q      <= busy_d;
    end
  end

  assign rf_addr         = idx_q;
  assign busy            = busy_q;
  assign done            = done_q;
  assign dump.dump_valid = valid_q;
  assign dump.dump_data  = data_q;
  assign dump.dump_index = index_q;
  assign dump.dump_last  = last_flag_q;
endmodule
